phi_sum_win: RTL and testbench

- Parametrised successor of the fixed 16-tap phi accumulator in the CFO/timing-sync datapath.
- Computes per-sample energy rho/2·(|r_k|²+|r_{k-N}|²) and a sliding-window sum over a runtime-selectable window length.
- Adds input/output valid qualification, a window-fill flag and a synchronous clear.
- Feeds the timing metric block downstream; input comes from the same sample/delay path as the correlator.

---
 rtl/phi_sum_win_if.sv | 49 ++++
 rtl/phi_sum_win.sv | 257 +++++++++++++++++++++++++
 tb/tb_phi_sum_win.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phi_sum_win_if.sv
// -----------------------------------------------------------------------------
// phi_sum_win_if
// Sample/result bundle for the phi sliding-window energy accumulator.
//
// Signals:
//   clear      synchronous flush of the window and pipeline, reloads win_len
//   win_len    requested window length, only taken at reset and on clear
//   in_valid   qualifies all sample inputs in this cycle
//   r_k_*      current complex sample, signed Q(R_W-R_FRAC).R_FRAC
//   r_kmN_*    complex sample delayed by N, same format
//   rho_in     signed rho weight
//   phi_out    windowed energy sum (signed, PHI_W bits)
//   phi_valid  phi_out updated this cycle
//   phi_full   window fully populated for this phi_out
//
// Modports:
//   master  sample source / result sink (testbench, upstream datapath)
//   slave   the accumulator itself
// -----------------------------------------------------------------------------
interface phi_sum_win_if #(
  parameter int R_W   = 8,
  parameter int RHO_W = 8,
  parameter int PHI_W = 14,
  parameter int L_MAX = 32
);
  localparam int WL_W = $clog2(L_MAX + 1);

  logic                    clear;
  logic [WL_W-1:0]         win_len;
  logic                    in_valid;
  logic signed [R_W-1:0]   r_k_re;
  logic signed [R_W-1:0]   r_k_im;
  logic signed [R_W-1:0]   r_kmN_re;
  logic signed [R_W-1:0]   r_kmN_im;
  logic signed [RHO_W-1:0] rho_in;
  logic signed [PHI_W-1:0] phi_out;
  logic                    phi_valid;
  logic                    phi_full;

  modport master (
    output clear, win_len, in_valid, r_k_re, r_k_im, r_kmN_re, r_kmN_im, rho_in,
    input  phi_out, phi_valid, phi_full
  );

  modport slave (
    input  clear, win_len, in_valid, r_k_re, r_k_im, r_kmN_re, r_kmN_im, rho_in,
    output phi_out, phi_valid, phi_full
  );
endinterface

// File: rtl/phi_sum_win.sv
// -----------------------------------------------------------------------------
// phi_sum_win
// Per-sample energy rho/2 * (|r_k|^2 + |r_{k-N}|^2) followed by a sliding-window
// sum over a window length chosen at reset/clear (1..L_MAX). Feeds the timing
// metric block.
//
// Pipeline:
//   S1  four component squares, rho registered
//   S2  |r_k|^2 and |r_{k-N}|^2 rescaled to PHI_FRAC, rho halved
//   S3  energy = rho_half * (sq_a + sq_b) >>> RHO_FRAC
//   S4  delay line shift, fill count, exact running sum (valid samples only)
//   OUT_LAT further registers on phi_out / phi_valid / phi_full
//   Latency in_valid -> phi_valid = 4 + OUT_LAT cycles, one sample per cycle.
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset (same effect as bus.clear)
//   bus   phi_sum_win_if.slave, sample inputs and windowed result
//
// Build option:
//   PHI_SUM_WIN_SAT_EN  defined: accumulator -> PHI_W conversion saturates
//                       undefined: two's-complement wrap (legacy behaviour)
// -----------------------------------------------------------------------------
module phi_sum_win #(
  parameter int R_W      = 8,
  parameter int R_FRAC   = 6,
  parameter int RHO_W    = 8,
  parameter int RHO_FRAC = 7,
  parameter int PHI_W    = 14,
  parameter int PHI_FRAC = 8,
  parameter int L_MAX    = 32,
  parameter int OUT_LAT  = 3
) (
  input  logic         clk,
  input  logic         rst,
  phi_sum_win_if.slave bus
);
  localparam int WL_W   = $clog2(L_MAX + 1);
  localparam int IDX_W  = (L_MAX > 1) ? $clog2(L_MAX) : 1;
  localparam int SQ_W   = 2 * R_W;
  localparam int SQS_W  = SQ_W + 1;
  localparam int SQ_SH  = 2 * R_FRAC - PHI_FRAC;
  localparam int TOT_W  = PHI_W + 1;
  localparam int PROD_W = RHO_W + TOT_W;
  localparam int ACC_W  = PHI_W + $clog2(L_MAX) + 1;

  // Reset and clear are indistinguishable inside the block.
  logic flush;
  assign flush = rst | bus.clear;

  // ---------------------------------------------------------------------------
  // Window length clamp: 0 -> 1, above L_MAX -> L_MAX
  // ---------------------------------------------------------------------------
  logic [WL_W-1:0] win_len_c;

  always_comb begin
    // NOTE: default assignment first so every path drives win_len_c; no latch.
    win_len_c = bus.win_len;
    if (bus.win_len == '0) begin
      win_len_c = WL_W'(1);
    end else if (bus.win_len > WL_W'(L_MAX)) begin
      win_len_c = WL_W'(L_MAX);
    end
  end

  // ---------------------------------------------------------------------------
  // S1: component squares
  // ---------------------------------------------------------------------------
  logic signed [SQ_W-1:0]  kre_x, kim_x, nre_x, nim_x;
  logic signed [SQ_W-1:0]  sq_kre_q, sq_kim_q, sq_nre_q, sq_nim_q;
  logic signed [RHO_W-1:0] rho_q;
  logic                    v1;

  // Sign-extend before multiplying so the full 2*R_W-bit product is kept.
  assign kre_x = SQ_W'(bus.r_k_re);
  assign kim_x = SQ_W'(bus.r_k_im);
  assign nre_x = SQ_W'(bus.r_kmN_re);
  assign nim_x = SQ_W'(bus.r_kmN_im);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours.
    if (flush) begin
      v1       <= 1'b0;
      sq_kre_q <= '0;
      sq_kim_q <= '0;
      sq_nre_q <= '0;
      sq_nim_q <= '0;
      rho_q    <= '0;
    end else begin
      v1       <= bus.in_valid;
      sq_kre_q <= kre_x * kre_x;
      sq_kim_q <= kim_x * kim_x;
      sq_nre_q <= nre_x * nre_x;
      sq_nim_q <= nim_x * nim_x;
      rho_q    <= bus.rho_in;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: magnitude squares at full precision, rescaled to PHI_FRAC
  // ---------------------------------------------------------------------------
  logic signed [SQS_W-1:0] sum_k, sum_n;
  logic signed [PHI_W-1:0] sq_a_d, sq_b_d, sq_a_q, sq_b_q;
  logic signed [RHO_W-1:0] rho_half_q;
  logic                    v2;

  always_comb begin
    sum_k  = SQS_W'(sq_kre_q) + SQS_W'(sq_kim_q);
    sum_n  = SQS_W'(sq_nre_q) + SQS_W'(sq_nim_q);
    sq_a_d = PHI_W'(sum_k >>> SQ_SH);
    sq_b_d = PHI_W'(sum_n >>> SQ_SH);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      v2         <= 1'b0;
      sq_a_q     <= '0;
      sq_b_q     <= '0;
      rho_half_q <= '0;
    end else begin
      v2         <= v1;
      sq_a_q     <= sq_a_d;
      sq_b_q     <= sq_b_d;
      rho_half_q <= rho_q >>> 1;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: weighted energy
  // ---------------------------------------------------------------------------
  logic signed [TOT_W-1:0]  sq_tot;
  logic signed [PROD_W-1:0] prod;
  logic signed [PHI_W-1:0]  energy_d, energy_q;
  logic                     v3;

  always_comb begin
    sq_tot   = TOT_W'(sq_a_q) + TOT_W'(sq_b_q);
    prod     = PROD_W'(rho_half_q) * PROD_W'(sq_tot);
    energy_d = PHI_W'(prod >>> RHO_FRAC);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      v3       <= 1'b0;
      energy_q <= '0;
    end else begin
      v3       <= v2;
      energy_q <= energy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S4: delay line and exact running sum
  // ---------------------------------------------------------------------------
  logic signed [PHI_W-1:0] taps [L_MAX];
  logic [WL_W-1:0]         fill_cnt;
  logic [WL_W-1:0]         win_len_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] oldest;
  logic [IDX_W-1:0]        tap_idx;
  logic                    v4;
  logic                    full_now;

  // Once the window is populated, the sample leaving it sits at tap win_len_q-1.
  assign tap_idx  = IDX_W'(win_len_q - WL_W'(1));
  assign oldest   = (fill_cnt == win_len_q) ? ACC_W'(taps[tap_idx]) : '0;
  assign full_now = (fill_cnt == win_len_q);

  always_ff @(posedge clk) begin
    if (flush) begin
      v4        <= 1'b0;
      fill_cnt  <= '0;
      acc_q     <= '0;
      win_len_q <= win_len_c;
      // NOTE: the delay line is cleared explicitly so a flush leaves no stale
      // taps behind; the fill count alone would mask them, but a clean state
      // keeps reset and clear behaviour identical and easy to reason about.
      for (int i = 0; i < L_MAX; i++) begin
        taps[i] <= '0;
      end
    end else begin
      v4 <= v3;
      if (v3) begin
        taps[0] <= energy_q;
        for (int i = 1; i < L_MAX; i++) begin
          taps[i] <= taps[i-1];
        end
        if (fill_cnt != win_len_q) begin
          fill_cnt <= fill_cnt + WL_W'(1);
        end
        acc_q <= acc_q + ACC_W'(energy_q) - oldest;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator -> PHI_W
  // ---------------------------------------------------------------------------
  logic signed [PHI_W-1:0] phi_red;

`ifdef PHI_SUM_WIN_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (PHI_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (PHI_W - 1)));

  always_comb begin
    phi_red = acc_q[PHI_W-1:0];
    if (acc_q > SAT_HI) begin
      phi_red = {1'b0, {(PHI_W-1){1'b1}}};
    end else if (acc_q < SAT_LO) begin
      phi_red = {1'b1, {(PHI_W-1){1'b0}}};
    end
  end
`else
  assign phi_red = acc_q[PHI_W-1:0];
`endif

  // ---------------------------------------------------------------------------
  // Output register chain. acc_q only moves on valid samples, so phi_out
  // naturally holds between valid outputs.
  // ---------------------------------------------------------------------------
  generate
    if (OUT_LAT > 0) begin : g_out_pipe
      logic signed [PHI_W-1:0] d_pipe [OUT_LAT];
      logic [OUT_LAT-1:0]      v_pipe;
      logic [OUT_LAT-1:0]      f_pipe;

      always_ff @(posedge clk) begin
        if (flush) begin
          v_pipe <= '0;
          f_pipe <= '0;
          for (int i = 0; i < OUT_LAT; i++) begin
            d_pipe[i] <= '0;
          end
        end else begin
          d_pipe[0] <= phi_red;
          v_pipe[0] <= v4;
          f_pipe[0] <= full_now;
          for (int i = 1; i < OUT_LAT; i++) begin
            d_pipe[i] <= d_pipe[i-1];
            v_pipe[i] <= v_pipe[i-1];
            f_pipe[i] <= f_pipe[i-1];
          end
        end
      end

      assign bus.phi_out   = d_pipe[OUT_LAT-1];
      assign bus.phi_valid = v_pipe[OUT_LAT-1];
      assign bus.phi_full  = f_pipe[OUT_LAT-1];
    end else begin : g_out_direct
      assign bus.phi_out   = phi_red;
      assign bus.phi_valid = v4;
      assign bus.phi_full  = full_now;
    end
  endgenerate

endmodule

// File: tb/tb_phi_sum_win.sv
// -----------------------------------------------------------------------------
// tb_phi_sum_win
// Self-checking bench for phi_sum_win. A reference model keeps the list of
// energies seen since the last flush, sums the newest win_len of them with
// plain integer arithmetic and schedules each result 4+OUT_LAT cycles after the
// sample was accepted. Directed scenarios add constant expectations.
// -----------------------------------------------------------------------------
module tb_phi_sum_win;
  localparam int R_W      = 8;
  localparam int R_FRAC   = 6;
  localparam int RHO_W    = 8;
  localparam int RHO_FRAC = 7;
  localparam int PHI_W    = 14;
  localparam int PHI_FRAC = 8;
  localparam int L_MAX    = 32;
  localparam int OUT_LAT  = 3;
  localparam int LAT      = 4 + OUT_LAT;
  localparam int WL_W     = $clog2(L_MAX + 1);

  // 16 samples of energy 1008 (63 * 2048 >>> 7) sum to 16128.
`ifdef PHI_SUM_WIN_SAT_EN
  localparam int SAT_16 = 8191;
`else
  localparam int SAT_16 = -256;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phi_sum_win_if #(.R_W(R_W), .RHO_W(RHO_W), .PHI_W(PHI_W), .L_MAX(L_MAX)) bus ();

  phi_sum_win #(
    .R_W(R_W), .R_FRAC(R_FRAC), .RHO_W(RHO_W), .RHO_FRAC(RHO_FRAC),
    .PHI_W(PHI_W), .PHI_FRAC(PHI_FRAC), .L_MAX(L_MAX), .OUT_LAT(OUT_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int due;
    int phi;
    bit full;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t pend[$];
  int   win_hist[$];
  int   win_eff  = 1;
  int   last_phi = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int wrapw(input int x, input int w);
    int m;
    m = x & ((1 << w) - 1);
    if (m >= (1 << (w - 1))) m = m - (1 << w);
    return m;
  endfunction

  function automatic int energy(input int kre, input int kim, input int nre,
                                input int nim, input int rho);
    int a, b, rh;
    a  = wrapw((kre * kre + kim * kim) >>> (2 * R_FRAC - PHI_FRAC), PHI_W);
    b  = wrapw((nre * nre + nim * nim) >>> (2 * R_FRAC - PHI_FRAC), PHI_W);
    rh = rho >>> 1;
    return wrapw((rh * (a + b)) >>> RHO_FRAC, PHI_W);
  endfunction

  function automatic int reduce(input int s);
`ifdef PHI_SUM_WIN_SAT_EN
    if (s > (1 << (PHI_W - 1)) - 1) return (1 << (PHI_W - 1)) - 1;
    if (s < -(1 << (PHI_W - 1)))    return -(1 << (PHI_W - 1));
    return s;
`else
    return wrapw(s, PHI_W);
`endif
  endfunction

  function automatic int clamp(input int w);
    if (w == 0) return 1;
    if (w > L_MAX) return L_MAX;
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_sample(input int kre, input int kim, input int nre,
                            input int nim, input int rho);
    bus.r_k_re   = R_W'(kre);
    bus.r_k_im   = R_W'(kim);
    bus.r_kmN_re = R_W'(nre);
    bus.r_kmN_im = R_W'(nim);
    bus.rho_in   = RHO_W'(rho);
  endtask

  task automatic set_rand_sample();
    set_sample(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
               int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
               int'($urandom_range(255)) - 128);
  endtask

  // Drive one cycle, update the model, advance past the edge and report what
  // the outputs are expected to show now.
  task automatic tick(input bit v, input bit clr, input bit rs,
                      output bit ev, output int eo, output bit ef);
    exp_t e;
    int   s;
    bus.in_valid = v;
    bus.clear    = clr;
    rst          = rs;
    if (rs || clr) begin
      pend.delete();
      win_hist.delete();
      last_phi = 0;
      win_eff  = clamp(int'(bus.win_len));
    end else if (v) begin
      win_hist.push_back(energy(int'(bus.r_k_re), int'(bus.r_k_im),
                                int'(bus.r_kmN_re), int'(bus.r_kmN_im),
                                int'(bus.rho_in)));
      if (win_hist.size() > win_eff) void'(win_hist.pop_front());
      s = 0;
      foreach (win_hist[i]) s += win_hist[i];
      e.due  = cyc + LAT;
      e.phi  = reduce(s);
      e.full = (win_hist.size() == win_eff);
      pend.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
    ev = 1'b0;
    eo = last_phi;
    ef = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e        = pend.pop_front();
      ev       = 1'b1;
      eo       = e.phi;
      ef       = e.full;
      last_phi = e.phi;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    bit ev, ef;
    int eo;
    bus.win_len = WL_W'(16);
    set_sample(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b1, ev, eo, ef);
      checks++;
      if (bus.phi_valid !== 1'b0 || bus.phi_out !== PHI_W'(0) || bus.phi_full !== 1'b0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got v=%0b out=%0d full=%0b exp v=0 out=0 full=0",
                 cyc, bus.phi_valid, bus.phi_out, bus.phi_full);
      end
    end
    tick(1'b0, 1'b0, 1'b0, ev, eo, ef);
    checks++;
    if (bus.phi_valid !== 1'b0 || bus.phi_out !== PHI_W'(0) || bus.phi_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_release cyc=%0d got v=%0b out=%0d full=%0b exp v=0 out=0 full=0",
               cyc, bus.phi_valid, bus.phi_out, bus.phi_full);
    end
  endtask

  task automatic test_ramp(input bit do_clear);
    bit ev, ef;
    int eo, n, exp_c;
    bus.win_len = WL_W'(16);
    set_sample(64, 0, 64, 0, 64);
    if (do_clear) tick(1'b0, 1'b1, 1'b0, ev, eo, ef);
    n = 0;
    for (int i = 1; i <= 32; i++) begin
      tick(i <= 24, 1'b0, 1'b0, ev, eo, ef);
      checks++;
      if (bus.phi_valid !== ev || bus.phi_out !== PHI_W'(eo) || (ev && bus.phi_full !== ef)) begin
        failures++;
        $display("FAIL ramp_stream cyc=%0d got v=%0b out=%0d full=%0b exp v=%0b out=%0d full=%0b",
                 cyc, bus.phi_valid, bus.phi_out, bus.phi_full, ev, eo, ef);
      end
      if (bus.phi_valid === 1'b1) begin
        n++;
        exp_c = 128 * ((n < 16) ? n : 16);
        checks++;
        if (bus.phi_out !== PHI_W'(exp_c) || bus.phi_full !== (n >= 16) || (n == 1 && i != 7)) begin
          failures++;
          $display("FAIL ramp_value tick=%0d out#%0d got out=%0d full=%0b exp out=%0d full=%0b first_tick=7",
                   i, n, bus.phi_out, bus.phi_full, exp_c, n >= 16);
        end
      end
    end
    checks++;
    if (n != 24) begin
      failures++;
      $display("FAIL ramp_count got %0d outputs exp 24", n);
    end
  endtask

  task automatic test_gapped();
    bit ev, ef;
    int eo, n, exp_c;
    bus.win_len = WL_W'(16);
    set_sample(64, 0, 64, 0, 64);
    tick(1'b0, 1'b1, 1'b0, ev, eo, ef);
    n = 0;
    for (int i = 1; i <= 44; i++) begin
      tick((i <= 32) && (i % 2 == 1), 1'b0, 1'b0, ev, eo, ef);
      checks++;
      if (bus.phi_valid !== ev || bus.phi_out !== PHI_W'(eo) || (ev && bus.phi_full !== ef)) begin
        failures++;
        $display("FAIL gapped_stream cyc=%0d got v=%0b out=%0d full=%0b exp v=%0b out=%0d full=%0b",
                 cyc, bus.phi_valid, bus.phi_out, bus.phi_full, ev, eo, ef);
      end
      if (bus.phi_valid === 1'b1) begin
        n++;
        exp_c = 128 * ((n < 16) ? n : 16);
        checks++;
        if (bus.phi_out !== PHI_W'(exp_c) || bus.phi_full !== (n >= 16)) begin
          failures++;
          $display("FAIL gapped_value out#%0d got out=%0d full=%0b exp out=%0d full=%0b",
                   n, bus.phi_out, bus.phi_full, exp_c, n >= 16);
        end
      end
    end
  endtask

  task automatic test_win4_step();
    bit ev, ef;
    int eo, n, exp_c;
    bus.win_len = WL_W'(4);
    tick(1'b0, 1'b1, 1'b0, ev, eo, ef);
    n = 0;
    for (int i = 1; i <= 24; i++) begin
      if (i <= 8) set_sample(64, 0, 64, 0, 64);
      else        set_sample(0, 0, 0, 0, 64);
      tick(i <= 16, 1'b0, 1'b0, ev, eo, ef);
      checks++;
      if (bus.phi_valid !== ev || bus.phi_out !== PHI_W'(eo) || (ev && bus.phi_full !== ef)) begin
        failures++;
        $display("FAIL win4_stream cyc=%0d got v=%0b out=%0d full=%0b exp v=%0b out=%0d full=%0b",
                 cyc, bus.phi_valid, bus.phi_out, bus.phi_full, ev, eo, ef);
      end
      if (bus.phi_valid === 1'b1) begin
        n++;
        if (n <= 8) exp_c = 128 * ((n < 4) ? n : 4);
        else        exp_c = 128 * ((n - 8 < 4) ? (4 - (n - 8)) : 0);
        checks++;
        if (bus.phi_out !== PHI_W'(exp_c) || bus.phi_full !== (n >= 4)) begin
          failures++;
          $display("FAIL win4_value out#%0d got out=%0d full=%0b exp out=%0d full=%0b",
                   n, bus.phi_out, bus.phi_full, exp_c, n >= 4);
        end
      end
    end
  endtask

  task automatic test_saturation();
    bit ev, ef;
    int eo, n;
    bus.win_len = WL_W'(16);
    set_sample(-128, 0, -128, 0, 127);
    tick(1'b0, 1'b1, 1'b0, ev, eo, ef);
    n = 0;
    for (int i = 1; i <= 28; i++) begin
      tick(i <= 20, 1'b0, 1'b0, ev, eo, ef);
      checks++;
      if (bus.phi_valid !== ev || bus.phi_out !== PHI_W'(eo) || (ev && bus.phi_full !== ef)) begin
        failures++;
        $display("FAIL sat_stream cyc=%0d got v=%0b out=%0d full=%0b exp v=%0b out=%0d full=%0b",
                 cyc, bus.phi_valid, bus.phi_out, bus.phi_full, ev, eo, ef);
      end
      if (bus.phi_valid === 1'b1) begin
        n++;
        if (n == 1) begin
          checks++;
          if (bus.phi_out !== PHI_W'(1008)) begin
            failures++;
            $display("FAIL sat_energy got out=%0d exp out=1008", bus.phi_out);
          end
        end
        if (n == 16) begin
          checks++;
          if (bus.phi_out !== PHI_W'(SAT_16) || bus.phi_full !== 1'b1) begin
            failures++;
            $display("FAIL sat_16th got out=%0d full=%0b exp out=%0d full=1",
                     bus.phi_out, bus.phi_full, SAT_16);
          end
        end
      end
    end
  endtask

  task automatic test_clear_mid();
    bit ev, ef;
    int eo;
    bus.win_len = WL_W'(16);
    set_sample(64, 0, 64, 0, 64);
    tick(1'b0, 1'b1, 1'b0, ev, eo, ef);
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 1'b0, 1'b0, ev, eo, ef);
      checks++;
      if (bus.phi_valid !== ev || bus.phi_out !== PHI_W'(eo) || (ev && bus.phi_full !== ef)) begin
        failures++;
        $display("FAIL clrmid_stream cyc=%0d got v=%0b out=%0d full=%0b exp v=%0b out=%0d full=%0b",
                 cyc, bus.phi_valid, bus.phi_out, bus.phi_full, ev, eo, ef);
      end
    end
    // clear and a valid sample in the same cycle: the sample must vanish
    tick(1'b1, 1'b1, 1'b0, ev, eo, ef);
    checks++;
    if (bus.phi_valid !== 1'b0 || bus.phi_out !== PHI_W'(0) || bus.phi_full !== 1'b0) begin
      failures++;
      $display("FAIL clrmid_flush got v=%0b out=%0d full=%0b exp v=0 out=0 full=0",
               bus.phi_valid, bus.phi_out, bus.phi_full);
    end
    test_ramp(1'b0);
  endtask

  task automatic test_clamp();
    bit ev, ef;
    int eo, n, exp_c;
    // win_len = 0 behaves as a one-sample window
    bus.win_len = WL_W'(0);
    tick(1'b0, 1'b1, 1'b0, ev, eo, ef);
    for (int i = 1; i <= 16; i++) begin
      set_rand_sample();
      tick(i <= 9, 1'b0, 1'b0, ev, eo, ef);
      checks++;
      if (bus.phi_valid !== ev || bus.phi_out !== PHI_W'(eo) || (ev && bus.phi_full !== 1'b1)) begin
        failures++;
        $display("FAIL clamp0_stream cyc=%0d got v=%0b out=%0d full=%0b exp v=%0b out=%0d full=1",
                 cyc, bus.phi_valid, bus.phi_out, bus.phi_full, ev, eo);
      end
    end
    // win_len = 40 behaves as L_MAX = 32
    bus.win_len = WL_W'(40);
    set_sample(64, 0, 64, 0, 64);
    tick(1'b0, 1'b1, 1'b0, ev, eo, ef);
    n = 0;
    for (int i = 1; i <= 44; i++) begin
      tick(i <= 36, 1'b0, 1'b0, ev, eo, ef);
      checks++;
      if (bus.phi_valid !== ev || bus.phi_out !== PHI_W'(eo) || (ev && bus.phi_full !== ef)) begin
        failures++;
        $display("FAIL clamp40_stream cyc=%0d got v=%0b out=%0d full=%0b exp v=%0b out=%0d full=%0b",
                 cyc, bus.phi_valid, bus.phi_out, bus.phi_full, ev, eo, ef);
      end
      if (bus.phi_valid === 1'b1) begin
        n++;
        exp_c = 128 * ((n < 32) ? n : 32);
        checks++;
        if (bus.phi_out !== PHI_W'(exp_c) || bus.phi_full !== (n >= 32)) begin
          failures++;
          $display("FAIL clamp40_value out#%0d got out=%0d full=%0b exp out=%0d full=%0b",
                   n, bus.phi_out, bus.phi_full, exp_c, n >= 32);
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    bit ev, ef;
    int eo;
    for (int i = 1; i <= 50; i++) begin
      set_rand_sample();
      if (i == 15) bus.win_len = WL_W'(8);
      tick(1'b1, 1'b0, (i == 15) || (i == 16), ev, eo, ef);
      checks++;
      if (bus.phi_valid !== ev || bus.phi_out !== PHI_W'(eo) || (ev && bus.phi_full !== ef)) begin
        failures++;
        $display("FAIL rstmid_stream cyc=%0d got v=%0b out=%0d full=%0b exp v=%0b out=%0d full=%0b",
                 cyc, bus.phi_valid, bus.phi_out, bus.phi_full, ev, eo, ef);
      end
    end
  endtask

  task automatic test_random();
    bit ev, ef;
    int eo;
    bit clr;
    for (int i = 1; i <= 400; i++) begin
      set_rand_sample();
      // win_len wanders freely; only a clear may pick it up
      bus.win_len = WL_W'($urandom_range(40));
      clr = ($urandom_range(39) == 0);
      tick($urandom_range(3) != 0, clr, 1'b0, ev, eo, ef);
      checks++;
      if (bus.phi_valid !== ev || bus.phi_out !== PHI_W'(eo) || (ev && bus.phi_full !== ef)) begin
        failures++;
        $display("FAIL random_stream cyc=%0d got v=%0b out=%0d full=%0b exp v=%0b out=%0d full=%0b",
                 cyc, bus.phi_valid, bus.phi_out, bus.phi_full, ev, eo, ef);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    bus.win_len  = WL_W'(16);
    set_sample(0, 0, 0, 0, 0);

    test_reset();
    test_ramp(1'b1);
    test_gapped();
    test_win4_step();
    test_saturation();
    test_clear_mid();
    test_clamp();
    test_rst_mid();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
